// File: rtl/row_mem_reader.sv
// Read-side sequencer for the IA and weight row memories: walks oc/ow/kw in
// convolution order and turns BRAM read data into aligned, masked PE beats.
module row_mem_reader #(
   parameter int INPUT_BW            = 8,
   parameter int IA_ROW_MEM_ADDR     = 6,
   parameter int WEIGHT_ROW_MEM_ADDR = 7,
   parameter int NUM_IA_ROW_MEM      = 96,
   parameter int NUM_WEIGHT_ROW_MEM  = 3
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     start,
   input  logic [2:0]                               K,
   input  logic [2:0]                               STRIDE,
   input  logic [5:0]                               IMG_W,
   input  logic [7:0]                               OC,
   input  logic [NUM_IA_ROW_MEM-1:0]                which_act_row_mem_activate,
   input  logic [NUM_WEIGHT_ROW_MEM-1:0]            which_weight_row_mem_activate,
   output logic [NUM_IA_ROW_MEM-1:0]                ia_row_mem_enb,
   output logic [IA_ROW_MEM_ADDR-1:0]               ia_row_mem_addrb,
   input  logic [NUM_IA_ROW_MEM*INPUT_BW-1:0]       ia_row_mem_doutb_flat,
   output logic [NUM_WEIGHT_ROW_MEM-1:0]            weight_row_mem_enb,
   output logic [WEIGHT_ROW_MEM_ADDR-1:0]           weight_row_mem_addrb,
   input  logic [NUM_WEIGHT_ROW_MEM*INPUT_BW-1:0]   weight_row_mem_doutb_flat,
   output logic [NUM_IA_ROW_MEM*INPUT_BW-1:0]       act_out_flat,
   output logic [NUM_WEIGHT_ROW_MEM*INPUT_BW-1:0]   weight_out_flat,
   output logic                                     out_valid,
   output logic                                     out_last,
   output logic                                     kw_last,
   input  logic                                     pe_ready,
   output logic                                     busy,
   output logic                                     done,
   output logic                                     cfg_err
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam int IA_DEPTH     = 1 << IA_ROW_MEM_ADDR;
   localparam int WEIGHT_DEPTH = 1 << WEIGHT_ROW_MEM_ADDR;

   logic [1:0]                          state;
   logic [2:0]                          k_r, stride_r;
   logic [5:0]                          img_w_r;
   logic [7:0]                          oc_r;
   logic [NUM_IA_ROW_MEM-1:0]           ia_mask;
   logic [NUM_WEIGHT_ROW_MEM-1:0]       w_mask;
   logic [2:0]                          kw_cnt;
   logic [5:0]                          ow_cnt;
   logic [7:0]                          oc_cnt;
   logic [IA_ROW_MEM_ADDR-1:0]          ia_base;
   logic [WEIGHT_ROW_MEM_ADDR-1:0]      w_base;
   logic                                s1_valid, s1_kw_last, s1_last;
   logic                                adv, issue;
   logic                                kw_at_end, ow_at_end, oc_at_end, final_issue;
   logic [9:0]                          ia_span;
   logic [10:0]                         w_span;
   logic                                bad_cfg;
   logic [NUM_IA_ROW_MEM*INPUT_BW-1:0]     act_masked;
   logic [NUM_WEIGHT_ROW_MEM*INPUT_BW-1:0] w_masked;

   // A stalled output register freezes the whole pipe, including address issue.
   assign adv   = !out_valid || pe_ready;
   assign issue = (state == RUN) && adv;

   assign kw_at_end   = (kw_cnt == k_r - 3'd1);
   assign ow_at_end   = (ow_cnt == img_w_r - 6'd1);
   assign oc_at_end   = (oc_cnt == oc_r - 8'd1);
   assign final_issue = kw_at_end && ow_at_end && oc_at_end;

   // Config check bounds the largest address, so the bases never overflow their width.
   assign ia_span = (10'(IMG_W) - 10'd1) * 10'(STRIDE) + 10'(K);
   assign w_span  = 11'(OC) * 11'(K);
   assign bad_cfg = (K == 3'd0) || (STRIDE == 3'd0) || (IMG_W == 6'd0) || (OC == 8'd0) ||
                    (ia_span > 10'(IA_DEPTH)) || (w_span > 11'(WEIGHT_DEPTH));

   assign ia_row_mem_enb       = issue ? ia_mask : '0;
   assign weight_row_mem_enb   = issue ? w_mask  : '0;
   assign ia_row_mem_addrb     = ia_base + IA_ROW_MEM_ADDR'(kw_cnt);
   assign weight_row_mem_addrb = w_base + WEIGHT_ROW_MEM_ADDR'(kw_cnt);

   assign busy = (state == RUN) || (state == DRAIN);
   assign done = (state == DONE);

   always_comb begin
      act_masked = '0;
      w_masked   = '0;
      for (int i = 0; i < NUM_IA_ROW_MEM; i++)
         if (ia_mask[i])
            act_masked[i*INPUT_BW +: INPUT_BW] = ia_row_mem_doutb_flat[i*INPUT_BW +: INPUT_BW];
      for (int j = 0; j < NUM_WEIGHT_ROW_MEM; j++)
         if (w_mask[j])
            w_masked[j*INPUT_BW +: INPUT_BW] = weight_row_mem_doutb_flat[j*INPUT_BW +: INPUT_BW];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         k_r      <= '0;
         stride_r <= '0;
         img_w_r  <= '0;
         oc_r     <= '0;
         ia_mask  <= '0;
         w_mask   <= '0;
         kw_cnt   <= '0;
         ow_cnt   <= '0;
         oc_cnt   <= '0;
         ia_base  <= '0;
         w_base   <= '0;
         cfg_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               k_r      <= K;
               stride_r <= STRIDE;
               img_w_r  <= IMG_W;
               oc_r     <= OC;
               ia_mask  <= which_act_row_mem_activate;
               w_mask   <= which_weight_row_mem_activate;
               kw_cnt   <= '0;
               ow_cnt   <= '0;
               oc_cnt   <= '0;
               ia_base  <= '0;
               w_base   <= '0;
               cfg_err  <= bad_cfg;
               state    <= bad_cfg ? DONE : RUN;
            end
            RUN: if (issue) begin
               if (!kw_at_end) begin
                  kw_cnt <= kw_cnt + 3'd1;
               end else begin
                  kw_cnt <= '0;
                  if (!ow_at_end) begin
                     ow_cnt  <= ow_cnt + 6'd1;
                     ia_base <= ia_base + IA_ROW_MEM_ADDR'(stride_r);
                  end else begin
                     ow_cnt  <= '0;
                     ia_base <= '0;
                     if (!oc_at_end) begin
                        oc_cnt <= oc_cnt + 8'd1;
                        w_base <= w_base + WEIGHT_ROW_MEM_ADDR'(k_r);
                     end
                  end
               end
               if (final_issue)
                  state <= DRAIN;
            end
            DRAIN: if (out_valid && pe_ready && out_last)
               state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

   // S1 tracks the beat whose BRAM data is on doutb now; S2 registers it for the PEs.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid        <= 1'b0;
         s1_kw_last      <= 1'b0;
         s1_last         <= 1'b0;
         out_valid       <= 1'b0;
         kw_last         <= 1'b0;
         out_last        <= 1'b0;
         act_out_flat    <= '0;
         weight_out_flat <= '0;
      end else if (adv) begin
         s1_valid        <= issue;
         s1_kw_last      <= issue && kw_at_end;
         s1_last         <= issue && final_issue;
         out_valid       <= s1_valid;
         kw_last         <= s1_kw_last;
         out_last        <= s1_last;
         act_out_flat    <= s1_valid ? act_masked : '0;
         weight_out_flat <= s1_valid ? w_masked : '0;
      end
   end

endmodule

// File: tb/tb_row_mem_reader.sv
// Randomized self-checking bench for row_mem_reader: behavioural row memories
// plus an index-based model of the convolution walk and beat timing.
module tb_row_mem_reader;

   logic          clk = 1'b0;
   logic          reset, start, pe_ready;
   logic [2:0]    K, STRIDE;
   logic [5:0]    IMG_W;
   logic [7:0]    OC;
   logic [95:0]   act_act;
   logic [2:0]    w_act;
   logic [95:0]   ia_enb;
   logic [5:0]    ia_addrb;
   logic [767:0]  ia_dout;
   logic [2:0]    w_enb;
   logic [6:0]    w_addrb;
   logic [23:0]   w_dout;
   logic [767:0]  act_out;
   logic [23:0]   w_out;
   logic          out_valid, out_last, kw_last, busy, done, cfg_err;

   logic [7:0]    ia_mem [96][64];
   logic [7:0]    w_mem  [3][128];

   int test_count = 0;
   int fail_count = 0;

   always #5 clk = ~clk;

   row_mem_reader dut (
      .clk(clk), .reset(reset), .start(start),
      .K(K), .STRIDE(STRIDE), .IMG_W(IMG_W), .OC(OC),
      .which_act_row_mem_activate(act_act),
      .which_weight_row_mem_activate(w_act),
      .ia_row_mem_enb(ia_enb), .ia_row_mem_addrb(ia_addrb),
      .ia_row_mem_doutb_flat(ia_dout),
      .weight_row_mem_enb(w_enb), .weight_row_mem_addrb(w_addrb),
      .weight_row_mem_doutb_flat(w_dout),
      .act_out_flat(act_out), .weight_out_flat(w_out),
      .out_valid(out_valid), .out_last(out_last), .kw_last(kw_last),
      .pe_ready(pe_ready), .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   // Row memories: registered read, doutb holds while enb is low.
   always @(posedge clk) begin
      for (int i = 0; i < 96; i++)
         if (ia_enb[i]) ia_dout[i*8 +: 8] <= ia_mem[i][ia_addrb];
      for (int j = 0; j < 3; j++)
         if (w_enb[j]) w_dout[j*8 +: 8] <= w_mem[j][w_addrb];
   end

   task automatic checkOutput(input string tag, input logic [767:0] actual, input logic [767:0] expected);
      test_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int k, input int s, input int w, input int oc,
                                input logic [95:0] iam, input logic [2:0] wm,
                                input int mode, input int abort_at);
      bit err;
      int total, cyc, issued, beats, stalls, first_valid;
      bit got_done, stall, prev_stall;
      logic [12:0] prev_addr;
      int kw, ow, o, idx;
      logic [767:0] exp_act;
      logic [23:0]  exp_w;

      err   = (k == 0) || (s == 0) || (w == 0) || (oc == 0) ||
              ((w - 1) * s + k > 64) || (oc * k > 128);
      total = err ? 0 : oc * w * k;

      @(negedge clk);
      K = 3'(k); STRIDE = 3'(s); IMG_W = 6'(w); OC = 8'(oc);
      act_act = iam; w_act = wm; start = 1'b1; pe_ready = 1'b1;
      cyc = 0; issued = 0; beats = 0; stalls = 0; first_valid = -1;
      got_done = 0; prev_stall = 0; prev_addr = '0;

      while (!got_done && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (abort_at > 0 && cyc == abort_at) begin
            reset = 1'b1;
            @(negedge clk);
            #1;
            checkOutput("abort_done", done, 1'b0);
            checkOutput("abort_busy", busy, 1'b0);
            checkOutput("abort_valid", out_valid, 1'b0);
            checkOutput("abort_enb", {ia_enb, w_enb}, '0);
            @(negedge clk);
            checkOutput("abort_done2", done, 1'b0);
            reset = 1'b0;
            return;
         end
         if (mode == 1)      pe_ready = !(cyc >= 8 && cyc <= 10);
         else if (mode == 2) pe_ready = ($urandom_range(0, 3) != 0);
         else                pe_ready = 1'b1;
         #1;
         if (cyc == 1) checkOutput("busy_after_start", busy, !err);
         stall = out_valid && !pe_ready;
         if (stall) begin
            stalls++;
            checkOutput("enb_in_stall", {ia_enb, w_enb}, '0);
            if (prev_stall) checkOutput("addr_hold", {ia_addrb, w_addrb}, prev_addr);
         end
         if (|ia_enb || |w_enb) begin
            if (issued < total) begin
               idx = issued;
               kw = idx % k; ow = (idx / k) % w; o = idx / (k * w);
               checkOutput("issue_enb", {ia_enb, w_enb}, {iam, wm});
               checkOutput("issue_addr", {ia_addrb, w_addrb}, {6'(ow * s + kw), 7'(o * k + kw)});
            end else begin
               checkOutput("extra_issue", issued, total);
            end
            issued++;
         end
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (out_valid && pe_ready) begin
            if (beats < total) begin
               idx = beats;
               kw = idx % k; ow = (idx / k) % w; o = idx / (k * w);
               exp_act = '0;
               exp_w   = '0;
               for (int i = 0; i < 96; i++)
                  if (iam[i]) exp_act[i*8 +: 8] = ia_mem[i][ow * s + kw];
               for (int j = 0; j < 3; j++)
                  if (wm[j]) exp_w[j*8 +: 8] = w_mem[j][o * k + kw];
               checkOutput("beat_act", act_out, exp_act);
               checkOutput("beat_weight", w_out, exp_w);
               checkOutput("beat_kw_last", kw_last, kw == k - 1);
               checkOutput("beat_out_last", out_last, idx == total - 1);
            end else begin
               checkOutput("extra_beat", beats, total);
            end
            beats++;
         end
         if (done) got_done = 1;
         prev_stall = stall;
         prev_addr  = {ia_addrb, w_addrb};
      end

      if (!got_done) begin
         checkOutput("done_timeout", got_done, 1'b1);
      end else begin
         checkOutput("cfg_err", cfg_err, err);
         checkOutput("beat_count", beats, total);
         checkOutput("issue_count", issued, total);
         checkOutput("done_cycle", cyc, err ? 1 : total + 3 + stalls);
         checkOutput("busy_at_done", busy, 1'b0);
         if (!err) checkOutput("first_valid_cycle", first_valid, 3);
         @(negedge clk);
         #1;
         checkOutput("done_pulse", done, 1'b0);
         checkOutput("cfg_err_hold", cfg_err, err);
      end
   endtask

   initial begin
      int rk, rs, rw, roc;
      reset = 1'b1; start = 1'b0; pe_ready = 1'b1;
      K = '0; STRIDE = '0; IMG_W = '0; OC = '0; act_act = '0; w_act = '0;
      ia_dout = '0; w_dout = '0;
      for (int i = 0; i < 96; i++)
         for (int a = 0; a < 64; a++) ia_mem[i][a] = 8'($urandom_range(1, 255));
      for (int j = 0; j < 3; j++)
         for (int a = 0; a < 128; a++) w_mem[j][a] = 8'($urandom_range(1, 255));

      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_valid", out_valid, 1'b0);
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_done", done, 1'b0);
      checkOutput("reset_cfg_err", cfg_err, 1'b0);
      checkOutput("reset_enb", {ia_enb, w_enb}, '0);
      checkOutput("reset_addr", {ia_addrb, w_addrb}, '0);
      checkOutput("reset_act", act_out, '0);
      reset = 1'b0;

      applyStimulus(3, 1, 4, 2, '1, 3'b111, 0, 0);
      applyStimulus(1, 2, 32, 1, '1, 3'b111, 0, 0);
      applyStimulus(3, 1, 4, 2, '1, 3'b111, 1, 0);
      applyStimulus(3, 2, 32, 1, '1, 3'b111, 0, 0);
      applyStimulus(3, 1, 4, 43, '1, 3'b111, 0, 0);
      applyStimulus(0, 1, 4, 2, '1, 3'b111, 0, 0);
      applyStimulus(2, 3, 5, 3, {64'd0, 32'hFFFF_FFFF}, 3'b101, 2, 0);
      applyStimulus(3, 1, 4, 2, '1, 3'b111, 0, 10);
      applyStimulus(3, 1, 4, 2, '1, 3'b111, 0, 0);

      for (int n = 0; n < 6; n++) begin
         rk = $urandom_range(1, 7); rs = $urandom_range(1, 7);
         rw = $urandom_range(1, 8); roc = $urandom_range(1, 4);
         applyStimulus(rk, rs, rw, roc, {$urandom, $urandom, $urandom},
                       3'($urandom_range(0, 7)), 2, 0);
      end

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
